srt_div_ctrl: RTL



---
 rtl/srt_div_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/srt_div_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | srt_div_ctrl : radix-2 SRT divider sequencer, on-the-fly Q/QM convert. |
// | Optional early termination on zero remainder: SRT_EARLY_TERM_EN.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module srt_div_ctrl #(
  parameter int WIDTH = 11,
  parameter int ITERS = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ITERS-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic [1:0]       mux_sel
);
  localparam int c_RW = WIDTH + 2;
  localparam int c_CW = $clog2(ITERS + 1);
  localparam logic [1:0] c_SEL_MINUS_D = 2'b00;
  localparam logic [1:0] c_SEL_ZERO    = 2'b01;
  localparam logic [1:0] c_SEL_PLUS_D  = 2'b10;
  localparam logic signed [c_RW-1:0] c_HALF  = c_RW'(1) << (WIDTH - 1);
  localparam logic signed [c_RW-1:0] c_NHALF = -c_HALF;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_CORR, S_DONE} state_t;

  state_t r_state, w_state_next;

  logic signed [c_RW-1:0] r_r;
  logic [WIDTH-1:0]       r_d;
  logic [ITERS-1:0]       r_q, r_qm;
  logic [c_CW-1:0]        r_cnt;

  logic signed [c_RW-1:0] w_r2, w_dext, w_r_next;
  logic                   w_qpos, w_qneg, w_valid, w_last, w_zero;
  logic [ITERS-1:0]       w_q_nx, w_qm_nx, w_q_upd, w_qm_upd;
  logic [WIDTH-1:0]       w_rem_corr;

  assign w_valid = d[WIDTH-1] & (x < d);
  assign w_r2    = {r_r[c_RW-2:0], 1'b0};
  assign w_dext  = {2'b00, r_d};
  assign w_qpos  = (w_r2 >= c_HALF);
  assign w_qneg  = (w_r2 < c_NHALF);
  assign w_last  = (r_cnt == c_CW'(ITERS - 1));
  // Low WIDTH bits of r+D are exact: the corrected remainder lies in [0, D).
  assign w_rem_corr = r_r[WIDTH-1:0] + r_d;

  always_comb begin
    w_r_next = w_r2;
    w_q_nx   = {r_q[ITERS-2:0], 1'b0};
    w_qm_nx  = {r_qm[ITERS-2:0], 1'b1};
    if (w_qpos) begin
      w_r_next = w_r2 - w_dext;
      w_q_nx   = {r_q[ITERS-2:0], 1'b1};
      w_qm_nx  = {r_q[ITERS-2:0], 1'b0};
    end else if (w_qneg) begin
      w_r_next = w_r2 + w_dext;
      w_q_nx   = {r_qm[ITERS-2:0], 1'b1};
      w_qm_nx  = {r_qm[ITERS-2:0], 1'b0};
    end
  end

`ifdef SRT_EARLY_TERM_EN
  logic [c_CW-1:0] w_shamt;
  assign w_zero   = (w_r_next == '0);
  assign w_shamt  = c_CW'(ITERS - 1) - r_cnt;
  assign w_q_upd  = w_zero ? (w_q_nx << w_shamt) : w_q_nx;
  assign w_qm_upd = w_zero ? ((w_q_nx << w_shamt) - ITERS'(1)) : w_qm_nx;
`else
  assign w_zero   = 1'b0;
  assign w_q_upd  = w_q_nx;
  assign w_qm_upd = w_qm_nx;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mux_sel      = c_SEL_ZERO;
    case (r_state)
      S_IDLE: if (start) w_state_next = w_valid ? S_ITER : S_DONE;
      S_ITER: begin
        busy = 1'b1;
        if (w_qpos)      mux_sel = c_SEL_MINUS_D;
        else if (w_qneg) mux_sel = c_SEL_PLUS_D;
        if (w_last || w_zero) w_state_next = S_CORR;
      end
      S_CORR: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_r   <= '0;
      r_d   <= '0;
      r_q   <= '0;
      r_qm  <= '0;
      r_cnt <= '0;
      err   <= 1'b0;
      quo   <= '0;
      rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          if (w_valid) begin
            r_r   <= {2'b00, x};
            r_d   <= d;
            r_q   <= '0;
            r_qm  <= '0;
            r_cnt <= '0;
            err   <= 1'b0;
          end else begin
            err <= 1'b1;
            quo <= '0;
            rem <= '0;
          end
        end
        S_ITER: begin
          r_r   <= w_r_next;
          r_q   <= w_q_upd;
          r_qm  <= w_qm_upd;
          r_cnt <= r_cnt + c_CW'(1);
        end
        S_CORR: begin
          if (r_r[c_RW-1]) begin
            quo <= r_qm;
            rem <= w_rem_corr;
          end else begin
            quo <= r_q;
            rem <= r_r[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire
